pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset sequencer on the far side of the board clock PLL. It drives the PLL `reset` input, watches the PLL `lock` output, and withholds the design's system reset until lock has been stable for a programmable time. It re-initialises the PLL on a lock timeout or a loss of lock. It runs on the free-running 50 MHz board clock that also feeds the PLL `clkin`, so it never depends on a PLL output clock.

## Interface
Parameters:
- `RESET_CYCLES`, default 100: cycles `pll_reset` is held high per PLL reset pulse (2 µs at 50 MHz).
- `LOCK_TIMEOUT`, default 50000: cycles allowed in WAIT_LOCK before the PLL is reset again (1 ms).
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock-high cycles required before releasing `sys_reset`.
- `CNT_W`, default `$clog2(max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))`: width of the phase counter.

Ports:
- `clk`, input, 1: 50 MHz board clock, free-running, not from the PLL.
- `reset`, input, 1: asynchronous, active-high (power-on / button).
- `pll_lock`, input, 1: PLL lock, asynchronous to `clk`.
- `pll_reset`, output, 1: drives the PLL reset input.
- `sys_reset`, output, 1: active-high reset for the rest of the design.
- `pll_ready`, output, 1: high only in RUN.
- `state`, output, 2: current state encoding, for debug and LED display.
- `relock_count`, output, 8: number of lock losses seen in RUN, saturating at 255.
- `timeout_count`, output, 8: number of WAIT_LOCK timeouts, saturating at 255.

## Operation
- `pll_lock` passes through a 2-FF synchronizer, giving `lock_s`. The FSM uses only `lock_s`.
- One phase counter `cnt` is cleared on every state entry and increments by one per cycle while in a state.
- States and encodings:
  - RESET_PLL = 0: `pll_reset`=1 and `sys_reset`=1. On `cnt`==RESET_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK = 1: `pll_reset`=0 and `sys_reset`=1.
    - If `lock_s`, go to STABLE.
    - Else if `cnt`==LOCK_TIMEOUT-1, go to RESET_PLL and increment `timeout_count` (saturating).
  - STABLE = 2: `sys_reset`=1.
    - If `!lock_s`, go to WAIT_LOCK. The counter restarts and the PLL is not reset.
    - Else if `cnt`==STABLE_CYCLES-1, go to RUN.
  - RUN = 3: `sys_reset`=0 and `pll_ready`=1. If `!lock_s`, go to RESET_PLL and increment `relock_count` (saturating).
- Simultaneous events:
  - WAIT_LOCK, lock rising on the timeout cycle: lock wins, so the next state is STABLE and `timeout_count` is unchanged.
  - STABLE, lock falling on the final cycle: lock loss wins, so the next state is WAIT_LOCK.
- Both counters saturate at 255; they never wrap. They clear only on `reset`.

## Timing
- Reset values: `state`=RESET_PLL, `cnt`=0, `pll_reset`=1, `sys_reset`=1, `pll_ready`=0, both counters 0, synchronizer flops 0.
- All outputs are registered and decoded from next-state, so they change on the same edge as `state`. There is no combinational path from input to output.
- `pll_reset` pulse width is exactly RESET_CYCLES cycles.
- `pll_lock` to FSM latency is 2 cycles.
- A lock drop in RUN raises `sys_reset` and `pll_reset` 3 edges after the `pll_lock` fall: 2 synchronizer edges plus 1 FSM edge.
- Asserting `reset` mid-operation immediately and asynchronously forces `pll_reset`=1 and `sys_reset`=1.
- Deassertion of `reset` is not synchronized here. The board-level POR provides a clean release.

## Structure
- Package `pll_sup_pkg` holds:
  - the `pll_sup_state_t` enum (RESET_PLL, WAIT_LOCK, STABLE, RUN) with the fixed encodings above;
  - the saturating-increment function used by both event counters.
- Sub-module `cdc_sync` is a parameterized N-stage (default 2) single-bit synchronizer with asynchronous active-high reset to 0. It is reused by other blocks.

## Test plan
The bench uses RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
- Steady bring-up: `pll_lock` held 1 from before `reset` release.
  - Required: `pll_reset` is high for edges 1–4 after release.
  - Required: `sys_reset` falls on edge 13 (4+1+8) and `pll_ready` rises on the same edge.
- No lock: `pll_lock`=0 for 200 cycles.
  - Required: `pll_reset` pulses of 4 cycles repeat every 24 cycles.
  - Required: `timeout_count` increments once per pulse and `sys_reset` stays 1.
- Glitch in STABLE: `pll_lock` low for 1 cycle, 3 cycles into STABLE.
  - Required: FSM returns to WAIT_LOCK with no `pll_reset` pulse.
  - Required: RUN is reached 8 stable cycles later.
- Lock loss in RUN: drop `pll_lock`.
  - Required: `sys_reset`=1 and `pll_reset`=1 exactly 3 edges later.
  - Required: `relock_count` reads 1.
  - Required: when lock is restored, the FSM re-enters RUN.
- Saturation: 300 lock drops in RUN.
  - Required: `relock_count` holds at 255.
- Async reset mid-STABLE: assert `reset` between clock edges.
  - Required: outputs reach their reset values before the next edge.
  - Required: after release, the sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared types and helpers for the PLL lock supervisor.
//   - pll_sup_state_t : FSM state encoding, also exported on the debug port
//   - sat_inc8        : saturating 8-bit increment for the event counters
//   - cnt_width       : phase counter width derived from the three phase lengths
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  // Holds at 255 instead of wrapping, so a stuck PLL never reads as "few events".
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Width able to hold the largest terminal count (max-1); never below 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cdc_sync.sv
// cdc_sync
//   N-stage single-bit synchronizer, asynchronous active-high reset to 0.
//   Ports:
//     clk   : destination clock
//     reset : asynchronous active-high reset
//     d     : asynchronous input
//     q     : synchronized output (STAGES edges of latency)
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift form keeps the code legal for any STAGES >= 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d);
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Pulses the PLL reset, waits for lock, requires lock to stay up for
//   STABLE_CYCLES before releasing the system reset, and re-initialises the
//   PLL on lock timeout or lock loss. Runs on the board clock, never on a
//   PLL output clock.
//   Ports:
//     clk           : free-running board clock (also PLL clkin)
//     reset         : asynchronous active-high power-on / button reset
//     pll_lock      : PLL lock, asynchronous to clk
//     pll_reset     : PLL reset input drive
//     sys_reset     : active-high reset for the rest of the design
//     pll_ready     : high only in RUN
//     state         : current FSM state (debug / LEDs)
//     relock_count  : lock losses seen in RUN, saturating at 255
//     timeout_count : WAIT_LOCK timeouts, saturating at 255
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   RESET_PLL | PLL held in reset for RESET_CYCLES
//   WAIT_LOCK | PLL released, waiting up to LOCK_TIMEOUT for lock
//   STABLE    | lock seen, must hold STABLE_CYCLES before release
//   RUN       | system reset released, watching for lock loss
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 100,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       pll_ready,
  output logic [1:0] state,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             lock_s;
  pll_sup_state_t   state_q;
  pll_sup_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             timeout_evt;
  logic             relock_evt;

  cdc_sync #(
    .STAGES(2)
  ) u_lock_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pll_lock),
    .q    (lock_s)
  );

  // Lock status is checked before the terminal count in WAIT_LOCK and
  // STABLE, so a lock edge coinciding with the last cycle wins.
  always_comb begin
    state_nxt   = state_q;
    timeout_evt = 1'b0;
    relock_evt  = 1'b0;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt == RESET_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt   = RESET_PLL;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt  = RESET_PLL;
          relock_evt = 1'b1;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
  end

  // Outputs are decoded from state_nxt so they move on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RESET_PLL;
      cnt           <= '0;
      pll_reset     <= 1'b1;
      sys_reset     <= 1'b1;
      pll_ready     <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      state_q <= state_nxt;
      // Counter holds at all-ones in RUN rather than wrapping; RUN ignores it.
      if (state_nxt != state_q) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      pll_reset <= (state_nxt == RESET_PLL);
      sys_reset <= (state_nxt != RUN);
      pll_ready <= (state_nxt == RUN);
      if (timeout_evt) timeout_count <= sat_inc8(timeout_count);
      if (relock_evt) relock_count <= sat_inc8(relock_count);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with RESET_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Every state change is an output event; stimulus queues
// the expected events (edge number since reset release plus all outputs)
// and a negedge monitor pops and compares them.
module tb_pll_lock_supervisor;

  typedef struct packed {
    int         cyc;
    logic [1:0] st;
    logic       pr;
    logic       sr;
    logic       rdy;
    logic [7:0] rc;
    logic [7:0] tc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       pll_ready;
  logic [1:0] state;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  ev_t  exp_q[$];
  ev_t  obs;
  ev_t  e;
  logic [1:0] prev_state;

  pll_lock_supervisor #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .sys_reset    (sys_reset),
    .pll_ready    (pll_ready),
    .state        (state),
    .relock_count (relock_count),
    .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge count since reset release: after edge n, cyc == n.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset && state !== prev_state) begin
      obs = '{cyc: cyc, st: state, pr: pll_reset, sr: sys_reset, rdy: pll_ready,
              rc: relock_count, tc: timeout_count};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d state=%0d pll_reset=%0d", cyc, state, pll_reset);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++;
          $display("FAIL event got cyc=%0d st=%0d pr=%0d sr=%0d rdy=%0d rc=%0d tc=%0d expected cyc=%0d st=%0d pr=%0d sr=%0d rdy=%0d rc=%0d tc=%0d",
                   obs.cyc, obs.st, obs.pr, obs.sr, obs.rdy, obs.rc, obs.tc,
                   e.cyc, e.st, e.pr, e.sr, e.rdy, e.rc, e.tc);
        end
      end
    end
    prev_state = state;
  end

  task automatic push(input int c, input logic [1:0] st, input int rc, input int tc);
    ev_t x;
    x.cyc = c;
    x.st  = st;
    x.pr  = (st == 2'd0);
    x.sr  = (st != 2'd3);
    x.rdy = (st == 2'd3);
    x.rc  = 8'(rc);
    x.tc  = 8'(tc);
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  // Leaves time at 1 ns after edge n.
  task automatic goto_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < n) begin
      checks++;
      errors++;
      $display("FAIL goto_cyc timeout got=%0d expected=%0d", cyc, n);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk({name, "_pending_events"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic lock_val);
    reset    = 1'b1;
    pll_lock = lock_val;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int b;
    int rc;
    reset    = 1'b0;
    pll_lock = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst_state", state, 0);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_pll_ready", pll_ready, 0);
    chk("rst_relock", relock_count, 0);
    chk("rst_timeout", timeout_count, 0);

    // Steady bring-up: lock high before release.
    do_reset(1'b1);
    push(4, 2'd1, 0, 0);
    push(5, 2'd2, 0, 0);
    push(13, 2'd3, 0, 0);
    goto_cyc(3);
    chk("bringup_pll_reset_edge3", pll_reset, 1);
    goto_cyc(12);
    chk("bringup_sys_reset_edge12", sys_reset, 1);
    goto_cyc(13);
    chk("bringup_sys_reset_edge13", sys_reset, 0);
    drain("bringup", 20);

    // No lock: 4-cycle pulses every 24 cycles, one timeout per pulse.
    do_reset(1'b0);
    for (int k = 0; k <= 8; k++) begin
      push(4 + 24 * k, 2'd1, 0, k);
      if (k < 8) push(24 + 24 * k, 2'd0, 0, k + 1);
    end
    goto_cyc(200);
    drain("nolock", 5);
    chk("nolock_sys_reset", sys_reset, 1);
    chk("nolock_timeouts", timeout_count, 8);

    // Lock arrives, then a one-cycle glitch 3 cycles into STABLE.
    pll_lock = 1'b1;
    push(203, 2'd2, 0, 8);
    push(208, 2'd1, 0, 8);
    push(209, 2'd2, 0, 8);
    push(217, 2'd3, 0, 8);
    goto_cyc(205);
    pll_lock = 1'b0;
    goto_cyc(206);
    pll_lock = 1'b1;
    goto_cyc(220);
    drain("glitch", 5);

    // Lock loss in RUN: resets rise exactly 3 edges after the drop.
    pll_lock = 1'b0;
    push(223, 2'd0, 1, 8);
    push(227, 2'd1, 1, 8);
    push(228, 2'd2, 1, 8);
    push(236, 2'd3, 1, 8);
    goto_cyc(222);
    chk("loss_sys_reset_edge2", sys_reset, 0);
    chk("loss_pll_reset_edge2", pll_reset, 0);
    goto_cyc(223);
    chk("loss_sys_reset_edge3", sys_reset, 1);
    chk("loss_pll_reset_edge3", pll_reset, 1);
    chk("loss_relock", relock_count, 1);
    goto_cyc(225);
    pll_lock = 1'b1;
    drain("loss", 30);

    // 300 further drops: relock_count saturates at 255.
    b = 240;
    for (int i = 0; i < 300; i++) begin
      rc = (2 + i > 255) ? 255 : 2 + i;
      goto_cyc(b);
      pll_lock = 1'b0;
      push(b + 3, 2'd0, rc, 8);
      push(b + 7, 2'd1, rc, 8);
      push(b + 8, 2'd2, rc, 8);
      push(b + 16, 2'd3, rc, 8);
      goto_cyc(b + 3);
      pll_lock = 1'b1;
      b = b + 20;
    end
    drain("sat", 40);
    chk("sat_relock", relock_count, 255);

    // Async reset in the middle of STABLE, then a full restart.
    do_reset(1'b1);
    push(4, 2'd1, 0, 0);
    push(5, 2'd2, 0, 0);
    goto_cyc(8);
    #3;
    reset = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_pll_reset", pll_reset, 1);
    chk("async_sys_reset", sys_reset, 1);
    chk("async_pll_ready", pll_ready, 0);
    chk("async_relock", relock_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(4, 2'd1, 0, 0);
    push(5, 2'd2, 0, 0);
    push(13, 2'd3, 0, 0);
    goto_cyc(1);
    chk("restart_pll_reset_edge1", pll_reset, 1);
    goto_cyc(4);
    chk("restart_pll_reset_edge4", pll_reset, 0);
    drain("restart", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
